mem_wb_stage: RTL and testbench

- MEM pipeline stage directly downstream of the EX/MEM register. It consumes that register's alu_result, rs2_data, rd and control outputs.
- Performs the word-sized load or store against an external data memory using a req/ready handshake, and stalls the pipeline while the memory is busy.
- Contains the MEM/WB pipeline register that feeds write-back. A timeout counter aborts hung accesses; misaligned accesses are flagged.

---
 rtl/mem_wb_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Purpose:
//   MEM pipeline stage placed directly after the EX/MEM register. It performs a
//   word load or store against an external data memory over a req/ready
//   handshake. While the memory is busy it stalls the upstream stages. It also
//   holds the MEM/WB pipeline register that feeds write-back.
//   A timeout counter aborts accesses that never complete. Accesses whose
//   address is not word aligned are rejected without issuing a request.
//
// Parameters:
//   TIMEOUT  maximum number of cycles dmem_req stays high for one access before
//            the access is aborted (legal range 2..255)
//   ADDR_W   width of dmem_addr (at most 32)
//
// Ports:
//   clk, reset                  clock; synchronous active-low reset
//   alu_result, rs2_data, rd    EX/MEM data: address or ALU result, store data,
//                               destination register
//   reg_write, mem_read,
//   mem_write, mem_to_reg       EX/MEM control bits
//   dmem_req, dmem_we,
//   dmem_addr, dmem_wdata       data memory request side
//   dmem_rdata, dmem_ready      data memory response side
//   stall                       freezes PC, IF/ID, ID/EX and EX/MEM
//   wb_*                        MEM/WB register contents
//   misaligned_err, bus_err     registered one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [31:0]       alu_result,
    input  logic [31:0]       rs2_data,
    input  logic [4:0]        rd,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,

    output logic              stall,

    output logic [31:0]       wb_alu_result,
    output logic [31:0]       wb_mem_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,

    output logic              misaligned_err,
    output logic              bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Value wait_cnt holds in the last cycle an access may stay outstanding.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;

    logic access;
    logic is_load;
    logic aligned;
    logic go;
    logic misaligned;
    logic abort;
    logic stall_int;

    // -------------------------------------------------------------------------
    // Access decode
    // -------------------------------------------------------------------------
    // When mem_read and mem_write are both set, the access is treated as a store.
    assign access     = mem_read | mem_write;
    assign is_load    = mem_read & ~mem_write;
    assign aligned    = (alu_result[1:0] == 2'b00);
    assign go         = access & aligned;
    assign misaligned = access & ~aligned;

    // An abort happens only in the final permitted cycle, and only when the
    // memory is still not ready. A ready in that same cycle is a completion.
    assign abort      = (state == WAIT) & ~dmem_ready & (wait_cnt == CNT_LAST);
    assign stall_int  = go & ~dmem_ready & ~abort;

    // -------------------------------------------------------------------------
    // Memory interface
    // -------------------------------------------------------------------------
    // The request is driven straight from the frozen EX/MEM contents. It stays
    // high for every cycle of the access and needs no state of its own.
    assign dmem_req   = go;
    assign dmem_we    = mem_write;
    assign dmem_addr  = alu_result[ADDR_W-1:0];
    assign dmem_wdata = rs2_data;
    assign stall      = stall_int;

    // -------------------------------------------------------------------------
    // Access FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values, whatever order the blocks run in.
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Access FSM: next state
    // -------------------------------------------------------------------------
    // wait_cnt counts the cycles dmem_req has already been high for this access.
    always_comb begin
        // NOTE: defaults come first so that every path assigns every output.
        // A path that skips an assignment would infer a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                // A zero-wait access completes here and never leaves IDLE.
                if (go && !dmem_ready) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            WAIT: begin
                if (dmem_ready || abort) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // MEM/WB pipeline register and error pulses
    // -------------------------------------------------------------------------
    // A bubble is loaded in three cases: while stalled, on an abort, and on a
    // rejected misaligned access. All fields are zeroed in a bubble, not only
    // wb_reg_write, so the register contents stay deterministic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_alu_result  <= 32'd0;
            wb_mem_data    <= 32'd0;
            wb_rd          <= 5'd0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            if (stall_int || abort || misaligned) begin
                wb_alu_result <= 32'd0;
                wb_mem_data   <= 32'd0;
                wb_rd         <= 5'd0;
                wb_reg_write  <= 1'b0;
                wb_mem_to_reg <= 1'b0;
            end else begin
                wb_alu_result <= alu_result;
                wb_mem_data   <= is_load ? dmem_rdata : 32'd0;
                wb_rd         <= rd;
                // x0 is never written, and stores never write the register file.
                wb_reg_write  <= reg_write & (rd != 5'd0) & ~mem_write;
                wb_mem_to_reg <= mem_to_reg;
            end
            misaligned_err <= misaligned;
            bus_err        <= abort;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Self-checking bench for mem_wb_stage, built with TIMEOUT=4. Each cycle of
// stimulus carries its expected values. The combinational outputs are compared
// shortly after the inputs are applied. The expected MEM/WB contents and error
// pulses are queued, then popped and compared just after the next rising edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [31:0] rdata;
        logic        ready;
    } in_t;

    typedef struct {
        logic        req;
        logic        we;
        logic        stall;
        logic [31:0] wb_alu;
        logic [31:0] wb_mem;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic        wb_m2r;
        logic        mis;
        logic        bus;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic        misaligned_err;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];

    mem_wb_stage #(
        .TIMEOUT (4),
        .ADDR_W  (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_result     (alu_result),
        .rs2_data       (rs2_data),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ready     (dmem_ready),
        .stall          (stall),
        .wb_alu_result  (wb_alu_result),
        .wb_mem_data    (wb_mem_data),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .misaligned_err (misaligned_err),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(input logic [31:0] alu, input logic [31:0] rs2,
                                  input logic [4:0] rd_v, input logic rw, input logic mr,
                                  input logic mw, input logic m2r,
                                  input logic [31:0] rdata, input logic ready);
        in_t i;
        i.alu = alu; i.rs2 = rs2; i.rd = rd_v; i.rw = rw; i.mr = mr;
        i.mw = mw; i.m2r = m2r; i.rdata = rdata; i.ready = ready;
        return i;
    endfunction

    function automatic exp_t mk_ex(input logic req, input logic we, input logic stl,
                                   input logic [31:0] wb_alu, input logic [31:0] wb_mem,
                                   input logic [4:0] wb_rd_v, input logic wb_rw,
                                   input logic wb_m2r, input logic mis, input logic bus);
        exp_t e;
        e.req = req; e.we = we; e.stall = stl; e.wb_alu = wb_alu; e.wb_mem = wb_mem;
        e.wb_rd = wb_rd_v; e.wb_rw = wb_rw; e.wb_m2r = wb_m2r; e.mis = mis; e.bus = bus;
        return e;
    endfunction

    // Expected values for a cycle that writes a bubble into MEM/WB.
    function automatic exp_t bubble(input logic req, input logic we, input logic stl,
                                    input logic mis, input logic bus);
        return mk_ex(req, we, stl, 32'd0, 32'd0, 5'd0, L, L, mis, bus);
    endfunction

    // Drive one cycle, check the combinational outputs, queue the registered
    // expectations, then pop and compare them after the edge.
    task automatic drive_cycle(input in_t i, input exp_t e, input string tag,
                               input logic rst_v = 1'b1);
        exp_t got;
        @(negedge clk);
        reset      = rst_v;
        alu_result = i.alu;
        rs2_data   = i.rs2;
        rd         = i.rd;
        reg_write  = i.rw;
        mem_read   = i.mr;
        mem_write  = i.mw;
        mem_to_reg = i.m2r;
        dmem_rdata = i.rdata;
        dmem_ready = i.ready;
        #1;
        check({tag, " dmem_req"},   {31'd0, dmem_req}, {31'd0, e.req});
        check({tag, " dmem_we"},    {31'd0, dmem_we},  {31'd0, e.we});
        check({tag, " stall"},      {31'd0, stall},    {31'd0, e.stall});
        check({tag, " dmem_addr"},  dmem_addr,         i.alu);
        check({tag, " dmem_wdata"}, dmem_wdata,        i.rs2);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: queue empty, expected one entry", tag);
        end else begin
            got = exp_q.pop_front();
            check({tag, " wb_alu_result"},  wb_alu_result,          got.wb_alu);
            check({tag, " wb_mem_data"},    wb_mem_data,            got.wb_mem);
            check({tag, " wb_rd"},          {27'd0, wb_rd},         {27'd0, got.wb_rd});
            check({tag, " wb_reg_write"},   {31'd0, wb_reg_write},  {31'd0, got.wb_rw});
            check({tag, " wb_mem_to_reg"},  {31'd0, wb_mem_to_reg}, {31'd0, got.wb_m2r});
            check({tag, " misaligned_err"}, {31'd0, misaligned_err}, {31'd0, got.mis});
            check({tag, " bus_err"},        {31'd0, bus_err},       {31'd0, got.bus});
        end
    endtask

    vec_t vecs[9];
    in_t  idle_in;
    in_t  acc;

    initial begin
        reset      = 1'b0;
        alu_result = 32'd0;
        rs2_data   = 32'd0;
        rd         = 5'd0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        dmem_rdata = 32'd0;
        dmem_ready = 1'b0;

        idle_in = mk_in(32'd0, 32'd0, 5'd0, L, L, L, L, 32'd0, L);

        // Single-cycle vectors, each starting in IDLE:
        // alu, rs2, rd, rw, mr, mw, m2r, rdata, ready
        // -> req, we, stall, wb_alu, wb_mem, wb_rd, wb_rw, wb_m2r, mis, bus
        // ALU op
        vecs[0] = '{mk_in(32'h1234, 32'h0, 5'd5, H, L, L, L, 32'h0, L),
                    mk_ex(L, L, L, 32'h1234, 32'h0, 5'd5, H, L, L, L)};
        // zero-wait load
        vecs[1] = '{mk_in(32'h100, 32'h0, 5'd7, H, H, L, H, 32'hDEADBEEF, H),
                    mk_ex(H, L, L, 32'h100, 32'hDEADBEEF, 5'd7, H, H, L, L)};
        // misaligned load
        vecs[2] = '{mk_in(32'h102, 32'h0, 5'd3, H, H, L, H, 32'h0, L),
                    bubble(L, L, L, H, L)};
        // load to x0
        vecs[3] = '{mk_in(32'h104, 32'h0, 5'd0, H, H, L, H, 32'h11112222, H),
                    mk_ex(H, L, L, 32'h104, 32'h11112222, 5'd0, L, H, L, L)};
        // zero-wait store
        vecs[4] = '{mk_in(32'h208, 32'h55, 5'd4, L, L, H, L, 32'h0, H),
                    mk_ex(H, H, L, 32'h208, 32'h0, 5'd4, L, L, L, L)};
        // read+write together is a store: no load data, no register write
        vecs[5] = '{mk_in(32'h20C, 32'h66, 5'd6, H, H, H, L, 32'hFFFF0000, H),
                    mk_ex(H, H, L, 32'h20C, 32'h0, 5'd6, L, L, L, L)};
        // misaligned store
        vecs[6] = '{mk_in(32'h203, 32'h77, 5'd2, L, L, H, L, 32'h0, H),
                    bubble(L, H, L, H, L)};
        // ALU op targeting x0
        vecs[7] = '{mk_in(32'hCAFE, 32'h0, 5'd0, H, L, L, L, 32'h0, L),
                    mk_ex(L, L, L, 32'hCAFE, 32'h0, 5'd0, L, L, L, L)};
        // ALU op with a stray ready/rdata: no load data captured
        vecs[8] = '{mk_in(32'h7, 32'h0, 5'd9, H, L, L, L, 32'h99, H),
                    mk_ex(L, L, L, 32'h7, 32'h0, 5'd9, H, L, L, L)};

        // Reset state
        drive_cycle(idle_in, bubble(L, L, L, L, L), "reset0", 1'b0);
        drive_cycle(idle_in, bubble(L, L, L, L, L), "reset1", 1'b0);

        for (int k = 0; k < 9; k++)
            drive_cycle(vecs[k].in, vecs[k].ex, $sformatf("vec%0d", k));

        // Store with 3 wait states: ready arrives in the 4th cycle.
        acc = mk_in(32'h200, 32'hA5A5A5A5, 5'd8, L, L, H, L, 32'h0, L);
        for (int c = 0; c < 3; c++)
            drive_cycle(acc, bubble(H, H, H, L, L), $sformatf("st_wait%0d", c));
        acc.ready = H;
        drive_cycle(acc, mk_ex(H, H, L, 32'h200, 32'h0, 5'd8, L, L, L, L), "st_done");

        // Timeout: ready never arrives, abort in the 4th cycle.
        acc = mk_in(32'h300, 32'h0, 5'd10, H, H, L, H, 32'h12345678, L);
        for (int c = 0; c < 3; c++)
            drive_cycle(acc, bubble(H, L, H, L, L), $sformatf("to_wait%0d", c));
        drive_cycle(acc, bubble(H, L, L, L, H), "to_abort");
        drive_cycle(vecs[0].in, vecs[0].ex, "to_after_alu");
        drive_cycle(vecs[1].in, vecs[1].ex, "to_after_load");

        // Ready in the abort cycle counts as completion.
        acc = mk_in(32'h310, 32'h0, 5'd12, H, H, L, H, 32'h0BADF00D, L);
        for (int c = 0; c < 3; c++)
            drive_cycle(acc, bubble(H, L, H, L, L), $sformatf("late_wait%0d", c));
        acc.ready = H;
        drive_cycle(acc, mk_ex(H, L, L, 32'h310, 32'h0BADF00D, 5'd12, H, H, L, L), "late_done");

        // Reset low in the 2nd WAIT cycle.
        acc = mk_in(32'h400, 32'h0, 5'd11, H, H, L, H, 32'h0, L);
        drive_cycle(acc, bubble(H, L, H, L, L), "rst_idle");
        drive_cycle(acc, bubble(H, L, H, L, L), "rst_wait1");
        drive_cycle(acc, bubble(H, L, H, L, L), "rst_wait2", 1'b0);
        check("rst state", {31'd0, dut.state}, 32'd0);
        check("rst wait_cnt", {24'd0, dut.wait_cnt}, 32'd0);
        acc = mk_in(32'h404, 32'h0, 5'd11, H, H, L, H, 32'h0, L);
        drive_cycle(acc, bubble(H, L, H, L, L), "post_rst_wait");
        acc.ready = H;
        acc.rdata = 32'h600D600D;
        drive_cycle(acc, mk_ex(H, L, L, 32'h404, 32'h600D600D, 5'd11, H, H, L, L), "post_rst_done");
        drive_cycle(idle_in, mk_ex(L, L, L, 32'h0, 32'h0, 5'd0, L, L, L, L), "final_nop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
